// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the fetch sequencer: state encoding and default geometry.
package pc_fetch_pkg;

    localparam int              DEF_PC_W         = 16;
    localparam int              DEF_INSTR_W      = 16;
    localparam int              DEF_PC_INC       = 2;
    localparam logic [15:0]     DEF_RESET_VECTOR = 16'h0000;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_sequencer.sv
// Fetch front end: drives the PC write port, fetches at pc_cur and hands instructions to decode.
// Optional misaligned-redirect trap enabled by defining ALIGN_CHECK_EN.
module pc_fetch_sequencer
    import pc_fetch_pkg::*;
#(
    parameter int              PC_W         = DEF_PC_W,
    parameter int              INSTR_W      = DEF_INSTR_W,
    parameter int              PC_INC       = DEF_PC_INC,
    parameter logic [PC_W-1:0] RESET_VECTOR = PC_W'(DEF_RESET_VECTOR)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PC_W-1:0]    pc_cur,
    output logic [PC_W-1:0]    pc_next,
    output logic               pc_write,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_target,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc
`ifdef ALIGN_CHECK_EN
    ,
    output logic               fetch_fault
`endif
);

    fetch_state_e    state_q;
    logic [PC_W-1:0] pc_inc;
    logic            bad_target;

    assign pc_inc = pc_cur + PC_W'(PC_INC);

`ifdef ALIGN_CHECK_EN
    assign bad_target = redirect_target[0];
`else
    assign bad_target = 1'b0;
`endif

    // PC write side is combinational; the boot write is gated by rst_n so reset stays inert.
    always_comb begin
        pc_write  = 1'b0;
        pc_next   = RESET_VECTOR;
        imem_req  = 1'b0;
        imem_addr = pc_cur;
        case (state_q)
            S_BOOT: begin
                pc_write = rst_n;
            end
            S_REQ: begin
                if (redirect_valid) begin
                    pc_write = ~bad_target;
                    pc_next  = redirect_target;
                end else begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        pc_write = 1'b1;
                        pc_next  = pc_inc;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_write = ~bad_target;
                    pc_next  = redirect_target;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_BOOT;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
`ifdef ALIGN_CHECK_EN
            fetch_fault <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_BOOT: state_q <= S_REQ;
                S_REQ, S_HOLD: begin
                    if (redirect_valid) begin
                        // Redirect wins: flush the held instruction and drop any same-cycle ack.
                        instr_valid <= 1'b0;
                        state_q     <= S_REQ;
`ifdef ALIGN_CHECK_EN
                        if (bad_target) begin
                            state_q     <= S_FAULT;
                            fetch_fault <= 1'b1;
                        end
`endif
                    end else if (state_q == S_REQ) begin
                        if (imem_ack) begin
                            instr       <= imem_rdata;
                            instr_pc    <= pc_cur;
                            instr_valid <= 1'b1;
                            state_q     <= S_HOLD;
                        end
                    end else if (instr_ready) begin
                        instr_valid <= 1'b0;
                        state_q     <= S_REQ;
                    end
                end
`ifdef ALIGN_CHECK_EN
                S_FAULT: state_q <= S_FAULT;
`endif
                default: state_q <= S_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer with a program-counter register closing the PC loop.
// Memory returns imem_addr ^ 16'hA5C3 as the instruction word.
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pc_cur;
    logic [15:0] pc_next;
    logic        pc_write;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] instr_pc;
`ifdef ALIGN_CHECK_EN
    logic        fetch_fault;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pc_fetch_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_cur          (pc_cur),
        .pc_next         (pc_next),
        .pc_write        (pc_write),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc)
`ifdef ALIGN_CHECK_EN
        ,
        .fetch_fault     (fetch_fault)
`endif
    );

    // programCounter stand-in; resets to a non-vector value so the boot write is visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        pc_cur <= 16'h1234;
        else if (pc_write) pc_cur <= pc_next;
    end

    assign imem_rdata = imem_addr ^ 16'hA5C3;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        logic [15:0] a;
        rst_n = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_target = 16'h0000;
        tick(); tick();

        check("rst_pc_write", {15'd0, pc_write}, 16'd0);
        check("rst_pc_next", pc_next, 16'h0000);
        check("rst_imem_req", {15'd0, imem_req}, 16'd0);
        check("rst_valid", {15'd0, instr_valid}, 16'd0);
        check("rst_instr", instr, 16'h0000);
        check("rst_instr_pc", instr_pc, 16'h0000);

        // Boot: one PC write to the reset vector.
        rst_n = 1'b1; #1;
        check("boot_pc_write", {15'd0, pc_write}, 16'd1);
        check("boot_pc_next", pc_next, 16'h0000);
        check("boot_req", {15'd0, imem_req}, 16'd0);
        tick();

        // Ack latency: request held three cycles, PC steady.
        for (int i = 0; i < 3; i++) begin
            check("wait_req", {15'd0, imem_req}, 16'd1);
            check("wait_addr", imem_addr, 16'h0000);
            check("wait_pc_cur", pc_cur, 16'h0000);
            check("wait_pc_write", {15'd0, pc_write}, 16'd0);
            if (i < 2) tick();
        end
        imem_ack = 1'b1; #1;
        check("ack_pc_write", {15'd0, pc_write}, 16'd1);
        check("ack_pc_next", pc_next, 16'h0002);
        tick();

        // Decode backpressure for five cycles.
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {15'd0, instr_valid}, 16'd1);
            check("bp_instr", instr, 16'hA5C3);
            check("bp_instr_pc", instr_pc, 16'h0000);
            check("bp_req", {15'd0, imem_req}, 16'd0);
            check("bp_pc_cur", pc_cur, 16'h0002);
            tick();
        end
        instr_ready = 1'b1;
        tick();

        // Streaming fetch at one instruction per two cycles.
        for (int i = 1; i <= 3; i++) begin
            a = 16'(2 * i);
            check("seq_req", {15'd0, imem_req}, 16'd1);
            check("seq_addr", imem_addr, a);
            check("seq_pc_next", pc_next, a + 16'd2);
            tick();
            check("seq_instr_pc", instr_pc, a);
            check("seq_instr", instr, a ^ 16'hA5C3);
            check("seq_valid", {15'd0, instr_valid}, 16'd1);
            tick();
        end

        // Redirect coincident with the ack of 0008: ack discarded.
        redirect_valid = 1'b1; redirect_target = 16'h0100; #1;
        check("rd_pc_write", {15'd0, pc_write}, 16'd1);
        check("rd_pc_next", pc_next, 16'h0100);
        check("rd_req_drop", {15'd0, imem_req}, 16'd0);
        tick();
        redirect_valid = 1'b0; #1;
        check("rd_pc_cur", pc_cur, 16'h0100);
        check("rd_instr_pc", instr_pc, 16'h0006);
        check("rd_valid", {15'd0, instr_valid}, 16'd0);
        check("rd_addr", imem_addr, 16'h0100);
        check("rd_pc_next", pc_next, 16'h0102);
        tick();
        check("rd_fetch_pc", instr_pc, 16'h0100);
        check("rd_fetch_ins", instr, 16'hA4C3);

        // Redirect in HOLD with ready=1 flushes, then wrap-around fetch.
        redirect_valid = 1'b1; redirect_target = 16'hFFFE; #1;
        check("wr_pc_next", pc_next, 16'hFFFE);
        check("wr_pc_write", {15'd0, pc_write}, 16'd1);
        tick();
        redirect_valid = 1'b0; #1;
        check("wr_flush", {15'd0, instr_valid}, 16'd0);
        check("wr_addr", imem_addr, 16'hFFFE);
        check("wr_pc_next0", pc_next, 16'h0000);
        tick();
        check("wr_instr_pc", instr_pc, 16'hFFFE);
        check("wr_instr", instr, 16'h5A3D);
        check("wr_pc_cur", pc_cur, 16'h0000);
        tick();
        imem_ack = 1'b0; #1;
        check("wr_next_addr", imem_addr, 16'h0000);
        check("wr_next_req", {15'd0, imem_req}, 16'd1);
        tick();

        // Asynchronous reset while waiting for an ack.
        rst_n = 1'b0; #1;
        check("mr_pc_write", {15'd0, pc_write}, 16'd0);
        check("mr_pc_next", pc_next, 16'h0000);
        check("mr_req", {15'd0, imem_req}, 16'd0);
        check("mr_valid", {15'd0, instr_valid}, 16'd0);
        check("mr_instr", instr, 16'h0000);
        check("mr_instr_pc", instr_pc, 16'h0000);
        tick();
        rst_n = 1'b1;
        tick();
        check("rb_pc_cur", pc_cur, 16'h0000);

        redirect_valid = 1'b1; redirect_target = 16'h0101; #1;
`ifdef ALIGN_CHECK_EN
        check("al_pc_write", {15'd0, pc_write}, 16'd0);
        tick();
        redirect_valid = 1'b0; #1;
        check("al_fault", {15'd0, fetch_fault}, 16'd1);
        check("al_pc_cur", pc_cur, 16'h0000);
        check("al_req", {15'd0, imem_req}, 16'd0);
        check("al_valid", {15'd0, instr_valid}, 16'd0);
        tick();
        imem_ack = 1'b1; #1;
        check("al_req_hold", {15'd0, imem_req}, 16'd0);
        check("al_pc_wr_hold", {15'd0, pc_write}, 16'd0);
        check("al_fault_hold", {15'd0, fetch_fault}, 16'd1);
`else
        check("odd_pc_write", {15'd0, pc_write}, 16'd1);
        check("odd_pc_next", pc_next, 16'h0101);
        tick();
        redirect_valid = 1'b0; #1;
        check("odd_addr", imem_addr, 16'h0101);
        check("odd_req", {15'd0, imem_req}, 16'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
